minimicro_ctrl_fsm: RTL and testbench
=====================================

Name: minimicro_ctrl_fsm

Overview:
- Multi-cycle control unit for the minimicro 16-bit core.
- Owns the PC, the instruction register and the Z/N flags.
- Decodes 4-bit opcodes (ADD/SUB/AND/OR/CMP/LDR/STR/BRANCH) and drives the ALU op (ALU_ADD/SUB/AND/OR), register-file and data-memory strobes.
- Sits between instruction memory and the datapath (register file, ALU, 256-entry data memory).

Parameters:
- DATA_WIDTH, 16, datapath/instruction width.
- PC_WIDTH, 8, PC and instruction-address width.
- DM_ADDR_WIDTH, 8, data-memory address width (256 entries).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  1 = leave FETCH and execute; 0 = hold in FETCH
- imem_addr  out  PC_WIDTH  current PC
- imem_rdata  in  DATA_WIDTH  instruction word (combinational read of imem_addr)
- alu_op  out  2  ALU operation
- alu_result  in  DATA_WIDTH  ALU output, used for flag capture
- rf_raddr_a  out  4  register-file read port A address
- rf_raddr_b  out  4  register-file read port B address
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  register-file write address
- rf_wsel  out  1  write-data select: 0 = ALU result, 1 = data-memory read data
- dm_addr  out  DM_ADDR_WIDTH  data-memory address
- dm_re  out  1  data-memory read enable
- dm_we  out  1  data-memory write enable (write data = register-file port B, wired outside this block)
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag
- halt  out  1  trap indication (optional feature only)

Behaviour:
- Instruction fields: op = IR[15:12]; A = IR[11:8]; B = IR[7:4]; C = IR[3:0]; imm8 = IR[7:0].
- ALU ops (ADD, SUB, AND, OR): rd = A, ra = B, rb = C.
- CMP: ra = B, rb = C; no writeback.
- LDR: rd = A, addr = imm8.
- STR: rs = A, addr = imm8.
- BRANCH: cond = A, target = imm8 (absolute).
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: if run=1, load IR <= imem_rdata, PC <= PC+1 (8-bit wrap, 0xFF -> 0x00), go to DECODE. If run=0, hold; no IR/PC change.
- DECODE:
  - ALU ops, CMP, BRANCH -> EXEC
  - LDR, STR -> MEM
  - undefined opcodes (0101, 1001-1111) -> FETCH as a NOP
- EXEC:
  - rf_raddr_a = B, rf_raddr_b = C.
  - alu_op: ADD->ALU_ADD, SUB->ALU_SUB, AND->ALU_AND, OR->ALU_OR, CMP->ALU_SUB; default ALU_ADD.
  - ALU ops and CMP capture flags at the end of EXEC: Z = (alu_result == 0), N = alu_result[15].
  - ALU ops -> WB; CMP -> FETCH.
  - BRANCH is evaluated on the current flags. BEQ (0000): taken if Z. BMI (0101): taken if N. B (1111): always taken. Any other cond: not taken.
  - Taken branch: PC <= imm8. Then -> FETCH.
- MEM:
  - dm_addr = imm8.
  - LDR: dm_re = 1 (1-cycle read latency), -> WB.
  - STR: rf_raddr_b = A, dm_we = 1 for exactly 1 cycle, -> FETCH.
- WB:
  - rf_we = 1 for exactly 1 cycle, rf_waddr = A.
  - rf_wsel = 1 for LDR, 0 for ALU ops.
  - -> FETCH.
- Cycle counts, with run held high:
  - ALU op: 4 cycles
  - CMP: 3 cycles
  - LDR: 4 cycles
  - STR: 3 cycles
  - BRANCH: 3 cycles, taken or not
- Flags change only on ALU ops and CMP; LDR, STR and BRANCH preserve them.
- Outputs are Moore-style functions of state and IR; there is no combinational path from imem_rdata or alu_result to any output.
- Strobes (rf_we, dm_we, dm_re) are forced to 0 whenever rst_n = 0.
- Reset (synchronous, any state, including mid-instruction): state = FETCH, PC = 0, IR = 0, flag_z = 0, flag_n = 0, halt = 0. All strobes are 0 in the cycle after reset. A pending write is aborted and never issued.
- run deasserted mid-instruction: no effect; the instruction completes and the FSM then holds in FETCH.

Optional Feature:
- Macro: MINIMICRO_ILLEGAL_TRAP_EN
- Defined: an undefined opcode in DECODE -> HALT. halt = 1 and stays set; no strobes; PC frozen. Only rst_n exits HALT.
- Undefined: undefined opcodes are 2-cycle NOPs (FETCH, DECODE, FETCH); halt is tied to 0; the HALT state does not exist.

Test Plan:
- Reset with PC=0x00; imem[0]=0x0123 (ADD r1,r2,r3); alu_result=0x0000 -> rf_we=1 with rf_waddr=1 in cycle 4, flag_z=1, flag_n=0, PC=0x01.
- imem: 0x4450 (CMP r5,r0) with alu_result=0x8001, then 0x8505 (BMI 0x05) -> flag_n=1, no rf_we; PC=0x05 after the branch EXEC.
- 0x6A10 (LDR r10,[0x10]) -> dm_re=1 with dm_addr=0x10 in cycle 3; cycle 4 rf_we=1, rf_wsel=1, rf_waddr=10. Then 0x7A20 (STR) -> single dm_we pulse, dm_addr=0x20, rf_raddr_b=10.
- PC=0xFF fetching 0x0000 -> PC wraps to 0x00. 0x8FAA (B 0xAA) -> PC=0xAA. 0x80AA (BEQ) with Z=0 -> PC unchanged (+1).
- rst_n=0 during WB of an ADD -> no rf_we; PC=0, state FETCH, flags 0. run=0 holds PC constant for 10 cycles.
- Opcode 0x9000: with MINIMICRO_ILLEGAL_TRAP_EN, halt=1 and PC frozen until reset; without it, a 2-cycle NOP and PC advances.

Source files
------------

// File: rtl/minimicro_ctrl_fsm.sv
// Multi-cycle control unit for the minimicro 16-bit core: PC, IR, Z/N flags and datapath strobes.
// Optional MINIMICRO_ILLEGAL_TRAP_EN: undefined opcodes trap into a sticky HALT state instead of acting as NOPs.
module minimicro_ctrl_fsm #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned PC_WIDTH      = 8,
    parameter int unsigned DM_ADDR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    output logic [PC_WIDTH-1:0]      imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic [1:0]               alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result,
    output logic [3:0]               rf_raddr_a,
    output logic [3:0]               rf_raddr_b,
    output logic                     rf_we,
    output logic [3:0]               rf_waddr,
    output logic                     rf_wsel,
    output logic [DM_ADDR_WIDTH-1:0] dm_addr,
    output logic                     dm_re,
    output logic                     dm_we,
    output logic                     flag_z,
    output logic                     flag_n,
    output logic                     halt
);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_BR  = 4'h8;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_MI = 4'h5;
    localparam logic [3:0] COND_AL = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef MINIMICRO_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [DATA_WIDTH-1:0]   ir_q;
    logic [3:0]              op;
    logic [3:0]              fa;
    logic [3:0]              fb;
    logic [3:0]              fc;
    logic [7:0]              imm8;
    logic                    is_alu;
    logic                    branch_taken;

    assign op        = ir_q[15:12];
    assign fa        = ir_q[11:8];
    assign fb        = ir_q[7:4];
    assign fc        = ir_q[3:0];
    assign imm8      = ir_q[7:0];
    assign is_alu    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    assign imem_addr = pc_q;

    // Next state and Moore outputs; strobes are qualified by rst_n so reset kills a pending write.
    always_comb begin
        state_d      = state_q;
        alu_op       = ALU_ADD;
        rf_raddr_a   = fb;
        rf_raddr_b   = fc;
        rf_waddr     = fa;
        rf_wsel      = (op == OP_LDR);
        dm_addr      = DM_ADDR_WIDTH'(imm8);
        rf_we        = 1'b0;
        dm_re        = 1'b0;
        dm_we        = 1'b0;
        branch_taken = 1'b0;

        case (op)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            OP_CMP:  alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase

        case (state_q)
            S_FETCH: begin
                if (run) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu || op == OP_CMP || op == OP_BR) begin
                    state_d = S_EXEC;
                end else if (op == OP_LDR || op == OP_STR) begin
                    state_d = S_MEM;
                end else begin
`ifdef MINIMICRO_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (op == OP_BR) begin
                    branch_taken = (fa == COND_AL) ||
                                   (fa == COND_EQ && flag_z) ||
                                   (fa == COND_MI && flag_n);
                end
                state_d = is_alu ? S_WB : S_FETCH;
            end
            S_MEM: begin
                if (op == OP_LDR) begin
                    dm_re   = rst_n;
                    state_d = S_WB;
                end else begin
                    rf_raddr_b = fa;
                    dm_we      = rst_n;
                    state_d    = S_FETCH;
                end
            end
            S_WB: begin
                rf_we   = rst_n;
                state_d = S_FETCH;
            end
`ifdef MINIMICRO_ILLEGAL_TRAP_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC, IR and flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH && run) begin
                ir_q <= imem_rdata;
                pc_q <= pc_q + PC_WIDTH'(1);
            end
            if (state_q == S_EXEC && (is_alu || op == OP_CMP)) begin
                flag_z <= (alu_result == '0);
                flag_n <= alu_result[DATA_WIDTH-1];
            end
            if (branch_taken) pc_q <= PC_WIDTH'(imm8);
        end
    end

`ifdef MINIMICRO_ILLEGAL_TRAP_EN
    // Sticky trap indication; only reset leaves HALT.
    always_ff @(posedge clk) begin
        if (!rst_n) halt <= 1'b0;
        else        halt <= (state_d == S_HALT);
    end
`else
    assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_minimicro_ctrl_fsm.sv
// Self-checking bench for minimicro_ctrl_fsm: scoreboarded strobes plus per-scenario inline checks.
module tb_minimicro_ctrl_fsm;

    localparam logic [1:0] K_RF = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_WR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] addr;
        logic [3:0] rg;
        logic       wsel;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [1:0]  alu_op;
    logic [15:0] alu_result;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic        rf_wsel;
    logic [7:0]  dm_addr;
    logic        dm_re;
    logic        dm_we;
    logic        flag_z;
    logic        flag_n;
    logic        halt;

    logic [15:0] imem [256];
    logic [7:0]  exp_pc;
    ev_t         sb[$];
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    assign imem_rdata = imem[imem_addr];

    minimicro_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wsel    (rf_wsel),
        .dm_addr    (dm_addr),
        .dm_re      (dm_re),
        .dm_we      (dm_we),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every rf_we/dm_re/dm_we cycle must match the next expected event.
    always @(negedge clk) begin
        ev_t act;
        ev_t exp;
        if (mon_en && (rf_we || dm_re || dm_we)) begin
            act.kind = rf_we ? K_RF : (dm_re ? K_RD : K_WR);
            act.addr = rf_we ? 8'h00 : dm_addr;
            act.rg   = rf_we ? rf_waddr : (dm_we ? rf_raddr_b : 4'h0);
            act.wsel = rf_we ? rf_wsel : 1'b0;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe: got rf_we=%b dm_re=%b dm_we=%b, required no strobe",
                         rf_we, dm_re, dm_we);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL sb_strobe: got kind=%0d addr=%h reg=%0d wsel=%b, required kind=%0d addr=%h reg=%0d wsel=%b",
                             act.kind, act.addr, act.rg, act.wsel, exp.kind, exp.addr, exp.rg, exp.wsel);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        exp_pc = 8'h00;
    endtask

    // Fetch and run one instruction to completion with run pulsed only in FETCH.
    task automatic run_instr(input logic [15:0] instr, input int ncyc);
        imem[exp_pc] = instr;
        exp_pc = exp_pc + 8'd1;
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (ncyc - 1) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b0;
        alu_result = 16'h0000;
        tick();
        tick();
        n_checks++;
        if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h, required 00", imem_addr); end
        n_checks++;
        if ({flag_z, flag_n} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got z=%b n=%b, required 0 0", flag_z, flag_n); end
        n_checks++;
        if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b, required 0", halt); end
        n_checks++;
        if ({rf_we, dm_re, dm_we} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b%b%b, required 000", rf_we, dm_re, dm_we);
        end
        rst_n  = 1'b1;
        exp_pc = 8'h00;
        mon_en = 1'b1;
    endtask

    task automatic test_alu_add();
        do_reset();
        imem[0] = 16'h0123;
        alu_result = 16'h0000;
        sb.push_back('{K_RF, 8'h00, 4'd1, 1'b0});
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        n_checks++;
        if ({alu_op, rf_raddr_a, rf_raddr_b} !== {2'b00, 4'd2, 4'd3}) begin
            n_fail++; $display("FAIL add_exec: got op=%0d ra=%0d rb=%0d, required 0 2 3", alu_op, rf_raddr_a, rf_raddr_b);
        end
        tick();
        n_checks++;
        if ({rf_we, rf_waddr} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL add_wb_cycle4: got we=%b waddr=%0d, required 1 1", rf_we, rf_waddr);
        end
        n_checks++;
        if ({flag_z, flag_n, imem_addr} !== {1'b1, 1'b0, 8'h01}) begin
            n_fail++; $display("FAIL add_flags_pc: got z=%b n=%b pc=%h, required 1 0 01", flag_z, flag_n, imem_addr);
        end
        tick();
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL add_we_pulse: got %b, required 0", rf_we); end
        exp_pc = 8'h01;
    endtask

    task automatic test_alu_ops();
        logic [15:0] res [3] = '{16'h1234, 16'hFFFF, 16'h0000};
        logic [1:0]  zn  [3] = '{2'b00, 2'b01, 2'b10};
        for (int i = 0; i < 3; i++) begin
            imem[exp_pc] = {4'(i + 1), 4'h7, 4'h2, 4'h3};
            exp_pc = exp_pc + 8'd1;
            alu_result = res[i];
            sb.push_back('{K_RF, 8'h00, 4'd7, 1'b0});
            run = 1'b1;
            tick();
            run = 1'b0;
            tick();
            n_checks++;
            if (alu_op !== 2'(i + 1)) begin n_fail++; $display("FAIL alu_op_%0d: got %0d, required %0d", i, alu_op, i + 1); end
            tick();
            n_checks++;
            if ({flag_z, flag_n} !== zn[i]) begin
                n_fail++; $display("FAIL alu_flags_%0d: got %b%b, required %b", i, flag_z, flag_n, zn[i]);
            end
            tick();
        end
    endtask

    task automatic test_cmp_branch();
        do_reset();
        alu_result = 16'h8001;
        imem[0] = 16'h4450;
        exp_pc = 8'h01;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        n_checks++;
        if ({alu_op, rf_raddr_a, rf_raddr_b} !== {2'b01, 4'd5, 4'd0}) begin
            n_fail++; $display("FAIL cmp_exec: got op=%0d ra=%0d rb=%0d, required 1 5 0", alu_op, rf_raddr_a, rf_raddr_b);
        end
        tick();
        n_checks++;
        if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL cmp_flags: got z=%b n=%b, required 0 1", flag_z, flag_n); end
        alu_result = 16'h0000;
        run_instr(16'h8505, 3);
        exp_pc = 8'h05;
        n_checks++;
        if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL bmi_taken: got pc %h, required %h", imem_addr, exp_pc); end
        n_checks++;
        if ({flag_z, flag_n} !== 2'b01) begin n_fail++; $display("FAIL br_keeps_flags: got %b%b, required 01", flag_z, flag_n); end
    endtask

    task automatic test_ldr_str();
        imem[exp_pc] = 16'h6A10;
        exp_pc = exp_pc + 8'd1;
        sb.push_back('{K_RD, 8'h10, 4'h0, 1'b0});
        sb.push_back('{K_RF, 8'h00, 4'd10, 1'b1});
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        n_checks++;
        if ({dm_re, dm_addr} !== {1'b1, 8'h10}) begin
            n_fail++; $display("FAIL ldr_cycle3: got re=%b addr=%h, required 1 10", dm_re, dm_addr);
        end
        tick();
        n_checks++;
        if ({rf_we, rf_wsel, rf_waddr} !== {1'b1, 1'b1, 4'd10}) begin
            n_fail++; $display("FAIL ldr_cycle4: got we=%b wsel=%b waddr=%0d, required 1 1 10", rf_we, rf_wsel, rf_waddr);
        end
        tick();
        sb.push_back('{K_WR, 8'h20, 4'd10, 1'b0});
        run_instr(16'h7A20, 3);
        n_checks++;
        if (dm_we !== 1'b0) begin n_fail++; $display("FAIL str_pulse: got dm_we=%b after MEM, required 0", dm_we); end
        n_checks++;
        if ({flag_n, imem_addr} !== {1'b1, exp_pc}) begin
            n_fail++; $display("FAIL mem_flags_pc: got n=%b pc=%h, required 1 %h", flag_n, imem_addr, exp_pc);
        end
    endtask

    task automatic test_pc_wrap_branch();
        run_instr(16'h8FFF, 3);
        exp_pc = 8'hFF;
        n_checks++;
        if (imem_addr !== 8'hFF) begin n_fail++; $display("FAIL b_to_ff: got %h, required ff", imem_addr); end
        alu_result = 16'h5555;
        sb.push_back('{K_RF, 8'h00, 4'd0, 1'b0});
        run_instr(16'h0000, 4);
        n_checks++;
        if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: got %h, required 00", imem_addr); end
        run_instr(16'h8FAA, 3);
        exp_pc = 8'hAA;
        n_checks++;
        if (imem_addr !== 8'hAA) begin n_fail++; $display("FAIL b_always: got %h, required aa", imem_addr); end
        run_instr(16'h80AA, 3);
        n_checks++;
        if (imem_addr !== 8'hAB) begin n_fail++; $display("FAIL beq_not_taken: got %h, required ab", imem_addr); end
        alu_result = 16'h0000;
        run_instr(16'h4012, 3);
        run_instr(16'h8330, 3);
        n_checks++;
        if (imem_addr !== 8'hAD) begin n_fail++; $display("FAIL bcond3_not_taken: got %h, required ad", imem_addr); end
        run_instr(16'h8030, 3);
        exp_pc = 8'h30;
        n_checks++;
        if (imem_addr !== 8'h30) begin n_fail++; $display("FAIL beq_taken: got %h, required 30", imem_addr); end
    endtask

    task automatic test_reset_mid_wb();
        imem[exp_pc] = 16'h0123;
        alu_result = 16'h8000;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        n_checks++;
        if (flag_n !== 1'b1) begin n_fail++; $display("FAIL pre_reset_flag: got n=%b, required 1", flag_n); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wb_abort: got rf_we=%b under reset, required 0", rf_we); end
        tick();
        rst_n = 1'b1;
        exp_pc = 8'h00;
        n_checks++;
        if ({imem_addr, flag_z, flag_n} !== {8'h00, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL mid_reset_state: got pc=%h z=%b n=%b, required 00 0 0", imem_addr, flag_z, flag_n);
        end
        tick();
        tick();
    endtask

    task automatic test_run_hold();
        run = 1'b0;
        imem[exp_pc] = 16'h0123;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL run_hold_%0d: got pc %h, required %h", i, imem_addr, exp_pc); end
        end
        alu_result = 16'h0001;
        run_instr(16'h4012, 3);
        n_checks++;
        if ({imem_addr, flag_z, flag_n} !== {exp_pc, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL after_hold: got pc=%h z=%b n=%b, required %h 0 0", imem_addr, flag_z, flag_n, exp_pc);
        end
    endtask

    task automatic test_illegal();
`ifdef MINIMICRO_ILLEGAL_TRAP_EN
        imem[exp_pc] = 16'h9000;
        exp_pc = exp_pc + 8'd1;
        run = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({halt, imem_addr} !== {1'b1, exp_pc}) begin
                n_fail++; $display("FAIL trap_%0d: got halt=%b pc=%h, required 1 %h", i, halt, imem_addr, exp_pc);
            end
            tick();
        end
        do_reset();
        n_checks++;
        if ({halt, imem_addr} !== {1'b0, 8'h00}) begin
            n_fail++; $display("FAIL trap_reset: got halt=%b pc=%h, required 0 00", halt, imem_addr);
        end
`else
        imem[exp_pc]         = 16'h9000;
        imem[exp_pc + 8'd1]  = 16'h5000;
        imem[exp_pc + 8'd2]  = 16'hF000;
        exp_pc = exp_pc + 8'd3;
        run = 1'b1;
        repeat (6) tick();
        run = 1'b0;
        n_checks++;
        if ({halt, imem_addr} !== {1'b0, exp_pc}) begin
            n_fail++; $display("FAIL nop_2cycle: got halt=%b pc=%h, required 0 %h", halt, imem_addr, exp_pc);
        end
        tick();
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        run = 1'b0;
        rst_n = 1'b0;
        exp_pc = 8'h00;
        test_reset();
        test_alu_add();
        test_alu_ops();
        test_cmp_branch();
        test_ldr_str();
        test_pc_wrap_branch();
        test_reset_mid_wb();
        test_run_hold();
        test_illegal();
        repeat (2) tick();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending events, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
